led_frame_scheduler: RTL and testbench
======================================

Name: led_frame_scheduler

Overview:
- Sequences the per-LED colour pipeline across a whole strip, one frame at a time.
- Drives `ledindex` into the colour pipeline and waits a fixed settle time, because that pipeline has a free-running 8-phase cycle.
- Captures the resulting red/green/blue and offers it to the WS2811 serialiser over a valid/ready handshake.
- After the last LED it holds a latch gap (line idle), then pulses `frame_done`.

Parameters:
- NUM_LEDS, 64, number of LEDs per frame; legal range 1..256.
- SETTLE_CYCLES, 16, clocks `ledindex` is held before colour is sampled; must be at least 2x the pipeline phase period; minimum 1.
- LATCH_CYCLES, 1000, clocks of latch gap after the last pixel is accepted; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  level; high = run frames back-to-back
- ledindex  out  8  index presented to the colour pipeline
- red_in  in  8  colour pipeline red output
- green_in  in  8  colour pipeline green output
- blue_in  in  8  colour pipeline blue output
- pix_data  out  24  {red, green, blue} for the serialiser
- pix_valid  out  1  pix_data holds an unconsumed pixel
- pix_ready  in  1  serialiser accepts pix_data this cycle
- pix_last  out  1  qualifies pix_data as pixel NUM_LEDS-1
- latch_active  out  1  high throughout the latch gap
- frame_start  out  1  one-cycle pulse when a frame begins
- frame_done  out  1  one-cycle pulse at end of latch gap
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, applies immediately, including mid-frame):
  - state=IDLE.
  - ledindex=0, pix_data=0, pix_valid=0, pix_last=0.
  - latch_active=0, frame_start=0, frame_done=0, busy=0.
  - All counters = 0.
- Handshake:
  - A transfer occurs on any edge where pix_valid && pix_ready.
  - pix_data and pix_last are stable while pix_valid=1 and no transfer has occurred.
  - pix_ready is ignored when pix_valid=0.
- State IDLE:
  - On an edge with enable=1: go to FETCH, ledindex<=0, settle_cnt<=0, frame_start=1 for that cycle.
- State FETCH (fetch side and output buffer run concurrently):
  - settle_cnt increments each edge until it reaches SETTLE_CYCLES-1, then holds.
  - Capture condition: settle_cnt==SETTLE_CYCLES-1 && fetch not finished && (pix_valid==0 || pix_ready==1).
  - On capture:
    - pix_data<={red_in, green_in, blue_in}, pix_valid<=1, pix_last<=(ledindex==NUM_LEDS-1).
    - If ledindex<NUM_LEDS-1: ledindex<=ledindex+1, settle_cnt<=0.
    - Otherwise: fetch finished; ledindex holds.
  - Capture while a transfer occurs on the same edge is a single-edge replace: pix_valid stays 1, no bubble.
  - A transfer with no capture on that edge clears pix_valid.
  - Timing: first pix_valid rises SETTLE_CYCLES edges after the edge that left IDLE.
  - No pixel is ever dropped or duplicated. Exactly NUM_LEDS transfers per frame, indices 0..NUM_LEDS-1 in order.
- Transfer with pix_last=1: go to LATCH, latch_cnt<=0, pix_valid<=0, pix_last<=0, latch_active<=1.
- State LATCH:
  - latch_cnt increments each edge.
  - On the edge where latch_cnt==LATCH_CYCLES-1: latch_active<=0 and frame_done=1 for one cycle.
  - Then if enable=1: go to FETCH with ledindex<=0, settle_cnt<=0, and frame_start pulses in the same cycle as frame_done.
  - If enable=0: go to IDLE.
- enable deasserted mid-frame: the current frame and its latch gap complete normally, then IDLE. A frame is never truncated.
- Special cases:
  - NUM_LEDS=1: the first capture already has pix_last=1.
  - ledindex never exceeds NUM_LEDS-1.
- Widths:
  - Counters are sized with $clog2 of their parameter (minimum 1 bit).
  - ledindex is 8 bits; NUM_LEDS=256 reaches index 255 without wrap.

Test Plan:
- NUM_LEDS=4, SETTLE=16, LATCH=20, pix_ready=1, colour model returns {idx, ~idx, idx^8'h55}:
  - pix_valid first rises 16 edges after leaving IDLE.
  - pix_data sequence 0x00FF55, 0x01FE54, 0x02FD57, 0x03FC56.
  - pix_last only on the 4th pixel.
  - latch_active high 20 cycles, then frame_done.
- Same config, pix_ready held low 50 cycles after the first valid:
  - pix_data stays 0x00FF55 throughout.
  - ledindex stays 1 while the settled capture is blocked.
  - On release, ledindex=2 next capture follows with no bubble.
- enable dropped 5 cycles after frame_start:
  - All 4 pixels are still delivered, latch completes, frame_done pulses.
  - Then IDLE with busy=0 and no further frame_start.
- enable held high:
  - frame_done and the next frame_start coincide.
  - Second frame repeats indices 0..3.
  - Exactly 8 transfers over the two frames.
- rst asserted mid-FETCH with pix_valid=1:
  - Outputs go to reset values without a clock edge.
  - After release with enable=1, the frame restarts at ledindex=0.
- NUM_LEDS=1:
  - A single transfer with pix_last=1, then LATCH.
  - ledindex never leaves 0.

Source files
------------

// File: rtl/led_frame_scheduler.sv
// Frame sequencer for a WS2811 strip. It walks ledindex across the strip and
// waits for the colour pipeline to settle, then hands each pixel to the serialiser.
module led_frame_scheduler #(
    parameter int NUM_LEDS      = 64,
    parameter int SETTLE_CYCLES = 16,
    parameter int LATCH_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [7:0]  ledindex,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        latch_active,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [LW-1:0] LATCH_LAST  = LW'(LATCH_CYCLES - 1);
    localparam logic [7:0]    LAST_IDX    = 8'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LATCH
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] settle_cnt;
    logic [LW-1:0] latch_cnt;
    logic          fetch_done;

    logic xfer;
    logic settled;
    logic capture;
    logic last_xfer;
    logic latch_end;

    assign xfer      = pix_valid && pix_ready;
    assign settled   = (settle_cnt == SETTLE_LAST);
    // The output buffer can take a new pixel when empty or being drained this edge.
    assign capture   = (state == FETCH) && settled && !fetch_done && (!pix_valid || pix_ready);
    assign last_xfer = (state == FETCH) && xfer && pix_last;
    assign latch_end = (state == LATCH) && (latch_cnt == LATCH_LAST);
    assign busy      = (state != IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        state_next  = state;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next  = FETCH;
                    frame_start = 1'b1;
                end
            end
            FETCH: begin
                if (last_xfer) state_next = LATCH;
            end
            LATCH: begin
                if (latch_end) begin
                    frame_done = 1'b1;
                    if (enable) begin
                        state_next  = FETCH;
                        frame_start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ledindex     <= 8'd0;
            settle_cnt   <= '0;
            latch_cnt    <= '0;
            fetch_done   <= 1'b0;
            pix_data     <= 24'd0;
            pix_valid    <= 1'b0;
            pix_last     <= 1'b0;
            latch_active <= 1'b0;
        end else begin
            state <= state_next;

            if (frame_start) begin
                ledindex   <= 8'd0;
                settle_cnt <= '0;
                fetch_done <= 1'b0;
            end else if (capture) begin
                if (ledindex != LAST_IDX) begin
                    ledindex   <= ledindex + 8'd1;
                    settle_cnt <= '0;
                end else begin
                    fetch_done <= 1'b1;
                end
            end else if (state == FETCH && !settled) begin
                settle_cnt <= settle_cnt + SW'(1);
            end

            // A capture on a transfer edge replaces the pixel without a bubble.
            if (capture) begin
                pix_data  <= {red_in, green_in, blue_in};
                pix_valid <= 1'b1;
                pix_last  <= (ledindex == LAST_IDX);
            end else if (xfer) begin
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
            end

            if (last_xfer) begin
                latch_cnt    <= '0;
                latch_active <= 1'b1;
            end else if (state == LATCH) begin
                if (latch_end) begin
                    latch_active <= 1'b0;
                    latch_cnt    <= '0;
                end else begin
                    latch_cnt <= latch_cnt + LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler: a 4-LED instance for the main flows
// and a 1-LED instance for the single-pixel frame.
module tb_led_frame_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-LED instance
    logic        enable;
    logic [7:0]  ledindex;
    logic [23:0] pix_data;
    logic        pix_valid, pix_ready, pix_last;
    logic        latch_active, frame_start, frame_done, busy;

    // 1-LED instance
    logic        enable_1;
    logic [7:0]  ledindex_1;
    logic [23:0] pix_data_1;
    logic        pix_valid_1, pix_ready_1, pix_last_1;
    logic        latch_active_1, frame_start_1, frame_done_1, busy_1;

    led_frame_scheduler #(.NUM_LEDS(4), .SETTLE_CYCLES(16), .LATCH_CYCLES(20)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .ledindex(ledindex),
        .red_in(ledindex), .green_in(~ledindex), .blue_in(ledindex ^ 8'h55),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .latch_active(latch_active), .frame_start(frame_start),
        .frame_done(frame_done), .busy(busy)
    );

    led_frame_scheduler #(.NUM_LEDS(1), .SETTLE_CYCLES(4), .LATCH_CYCLES(5)) u_one (
        .clk(clk), .rst(rst), .enable(enable_1), .ledindex(ledindex_1),
        .red_in(ledindex_1), .green_in(~ledindex_1), .blue_in(ledindex_1 ^ 8'h55),
        .pix_data(pix_data_1), .pix_valid(pix_valid_1), .pix_ready(pix_ready_1),
        .pix_last(pix_last_1), .latch_active(latch_active_1), .frame_start(frame_start_1),
        .frame_done(frame_done_1), .busy(busy_1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int idx);
        logic [7:0] i;
        i = 8'(idx);
        return {i, ~i, i ^ 8'h55};
    endfunction

    // Transfer and pulse monitor, sampled on the inactive edge.
    logic [23:0] xfer_q[$];
    logic        last_q[$];
    int latch_run = 0, latch_len = 0, n_start = 0;
    int n_xfer_1 = 0, max_idx_1 = 0;
    logic [23:0] data_1;
    logic        last_1;

    always @(negedge clk) begin
        if (pix_valid && pix_ready) begin
            xfer_q.push_back(pix_data);
            last_q.push_back(pix_last);
        end
        if (latch_active) latch_run++;
        if (frame_done) begin
            latch_len = latch_run;
            latch_run = 0;
        end
        if (frame_start) n_start++;
        if (pix_valid_1 && pix_ready_1) begin
            n_xfer_1++;
            data_1 = pix_data_1;
            last_1 = pix_last_1;
        end
        if (int'(ledindex_1) > max_idx_1) max_idx_1 = int'(ledindex_1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!frame_done && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, 32'(frame_done), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!pix_valid && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_valid_seen"}, 32'(pix_valid), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int starts;
        int k;
        rst = 1'b1; enable = 1'b0; pix_ready = 1'b1;
        enable_1 = 1'b0; pix_ready_1 = 1'b1;
        #2;
        check("rst_ledindex", 32'(ledindex), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_flags", {26'd0, pix_valid, pix_last, latch_active, frame_start, frame_done, busy}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic frame with pix_ready high, then a back-to-back second frame.
        enable = 1'b1;
        #1;
        check("idle_frame_start", 32'(frame_start), 32'd1);
        tick();
        check("fetch_busy", 32'(busy), 32'd1);
        tick(15);
        check("valid_not_before_16", 32'(pix_valid), 32'd0);
        tick();
        check("valid_at_16", 32'(pix_valid), 32'd1);
        check("first_pix", 32'(pix_data), 32'(exp_pix(0)));
        wait_done("f1", 400);
        check("start_with_done", 32'(frame_start), 32'd1);
        #5;
        check("latch_len", 32'(latch_len), 32'd20);
        check("f1_count", 32'(xfer_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (xfer_q.size() > i) begin
                check($sformatf("f1_pix%0d", i), 32'(xfer_q[i]), 32'(exp_pix(i)));
                check($sformatf("f1_last%0d", i), 32'(last_q[i]), 32'(i == 3));
            end
        end

        // Drop enable 5 cycles into the second frame; it must still complete.
        tick(5);
        enable = 1'b0;
        wait_done("f2", 400);
        check("no_restart_at_done", 32'(frame_start), 32'd0);
        #5;
        check("two_frame_count", 32'(xfer_q.size()), 32'd8);
        for (int i = 4; i < 8; i++) begin
            if (xfer_q.size() > i)
                check($sformatf("f2_pix%0d", i - 4), 32'(xfer_q[i]), 32'(exp_pix(i - 4)));
        end
        tick();
        check("f2_idle", 32'(busy), 32'd0);
        starts = n_start;
        tick(30);
        check("no_extra_start", 32'(n_start), 32'(starts));
        check("stays_idle", 32'(busy), 32'd0);

        // Backpressure: pix_ready low for 50 cycles after the first valid.
        xfer_q.delete();
        last_q.delete();
        pix_ready = 1'b0;
        enable = 1'b1;
        wait_valid("bp", 100);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pix_data !== exp_pix(0) || pix_valid !== 1'b1) bad++;
        end
        check("bp_hold_data", 32'(bad), 32'd0);
        check("bp_ledindex", 32'(ledindex), 32'd1);
        pix_ready = 1'b1;
        tick();
        check("bp_replace_data", 32'(pix_data), 32'(exp_pix(1)));
        check("bp_no_bubble", 32'(pix_valid), 32'd1);
        check("bp_ledindex_next", 32'(ledindex), 32'd2);
        enable = 1'b0;
        wait_done("bp", 400);
        #5;
        check("bp_count", 32'(xfer_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (xfer_q.size() > i)
                check($sformatf("bp_pix%0d", i), 32'(xfer_q[i]), 32'(exp_pix(i)));
        end
        tick(2);

        // Asynchronous reset mid-FETCH while a pixel is pending.
        pix_ready = 1'b0;
        enable = 1'b1;
        wait_valid("rs", 100);
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(pix_valid), 32'd0);
        check("arst_data", 32'(pix_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tick(2);
        rst = 1'b0;
        pix_ready = 1'b1;
        tick();
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_index", 32'(ledindex), 32'd0);
        wait_valid("rs2", 100);
        check("restart_pix", 32'(pix_data), 32'(exp_pix(0)));
        enable = 1'b0;
        wait_done("rs", 400);
        tick(2);

        // Single-LED strip.
        enable_1 = 1'b1;
        tick();
        enable_1 = 1'b0;
        k = 0;
        while (!frame_done_1 && k < 100) begin
            tick();
            k++;
        end
        check("one_done_seen", 32'(frame_done_1), 32'd1);
        #5;
        check("one_count", 32'(n_xfer_1), 32'd1);
        check("one_data", 32'(data_1), 32'(exp_pix(0)));
        check("one_last", 32'(last_1), 32'd1);
        check("one_max_index", 32'(max_idx_1), 32'd0);
        tick();
        check("one_idle", 32'(busy_1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
